collision_detector: RTL and testbench
=====================================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter MIN_OVERLAP, default 4: overlap pixels per frame needed to declare a hit (1..1023).
REQ-002 SHALL have parameter GRACE_FRAMES, default 60: frames ignored after game_reset, used only when COLLISION_GRACE_EN is defined (1..255).
REQ-003 SHALL have port clk, input, 1: the single system clock.
REQ-004 SHALL have port hard_reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port game_en, input, 1: high while the game is in the playing state.
REQ-006 SHALL have port game_reset, input, 1: one-cycle pulse that clears all gameplay state.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse marking the end of the active frame.
REQ-008 SHALL have port video_on, input, 1: high when the current pixel is in the visible area.
REQ-009 SHALL have port player_on, input, 1: player sprite pixel is opaque at the current pixel.
REQ-010 SHALL have port obstacle_on, input, 1: any obstacle pixel is opaque at the current pixel.
REQ-011 SHALL have ports pixel_x and pixel_y, input, 10 each: current scan coordinates.
REQ-012 SHALL have port collision, output, 1: registered hit level, held until game_reset.
REQ-013 SHALL have ports hit_x and hit_y, output, 10 each: first overlap coordinate of the frame that caused the hit.
REQ-014 SHALL have port armed, output, 1: high when the block is able to declare a hit.

Function
REQ-015 SHALL define overlap as video_on & player_on & obstacle_on, and SHALL count it only while game_en=1.
REQ-016 SHALL hold overlap_cnt as a 10-bit counter that saturates at 1023 and never wraps.
REQ-017 SHALL capture pixel_x and pixel_y into first_x and first_y on the first counted overlap of each frame (overlap_cnt==0).
REQ-018 SHALL implement FSM states GRACE, ARMED and HIT, with armed=1 only in ARMED.
REQ-019 SHALL, on frame_tick, evaluate cnt_eval = overlap_cnt + that cycle's overlap (saturated); the tick cycle's pixel belongs to the closing frame.
REQ-020 SHALL, in ARMED with frame_tick, game_en=1 and cnt_eval >= MIN_OVERLAP, enter HIT and set collision=1 on the next clock edge.
REQ-021 SHALL load hit_x and hit_y with the closing frame's first overlap coordinate in the same edge that enters HIT (the tick-cycle coordinate if cnt_eval counted only the tick pixel).
REQ-022 SHALL clear overlap_cnt and the first-overlap flag on every frame_tick, in all states.
REQ-023 SHALL, in HIT, keep collision=1, keep hit_x/hit_y stable, and ignore frame_tick evaluation and game_en until game_reset.
REQ-024 SHALL, in GRACE, decrement a grace counter on each frame_tick and enter ARMED when the counter reaches 0 on a tick.
REQ-025 SHALL, on game_reset, on the next clock edge: set collision=0; clear hit_x, hit_y and overlap_cnt; load grace counter with GRACE_FRAMES; enter GRACE (macro defined) or ARMED (macro undefined).
REQ-026 SHALL give game_reset priority over frame_tick and overlap when they coincide.
REQ-027 SHALL, while game_en=0 and not in HIT, freeze the state and grace counter; frame_tick still clears overlap_cnt.
REQ-028 SHALL have a latency from tick to collision of exactly 1 clock.

Reset
REQ-029 SHALL, on hard_reset, asynchronously force state=ARMED, collision=0, hit_x=hit_y=0, overlap_cnt=0 and grace counter=0.
REQ-030 SHALL, on hard_reset mid-frame, discard the partial-frame count; the next frame counts from 0.

Configuration
REQ-031 SHALL, with COLLISION_GRACE_EN defined, include the grace counter and the GRACE state and behave per REQ-024/025.
REQ-032 SHALL, without COLLISION_GRACE_EN, omit GRACE and its counter; game_reset enters ARMED and GRACE_FRAMES is unused.

Structure
REQ-033 SHALL place the state encodings (GRACE=2'b00, ARMED=2'b01, HIT=2'b10), COORD_W=10 and CNT_MAX=1023 in shared package collision_pkg.
REQ-034 SHALL implement the saturating per-frame count and first-coordinate capture in sub-module overlap_counter; the FSM and output registers stay in collision_detector.

Verification
REQ-035 SHALL cover: macro undefined, MIN_OVERLAP=4, 4 overlap pixels starting at (100,200), then tick -> collision=1 one clock after the tick, hit_x=100, hit_y=200.
REQ-036 SHALL cover: 3 overlap pixels, then tick -> collision stays 0 and overlap_cnt=0 after the tick.
REQ-037 SHALL cover: 3 overlap pixels, plus a 4th overlap pixel on the tick cycle -> collision=1.
REQ-038 SHALL cover: macro defined, GRACE_FRAMES=2, game_reset, then heavy overlap in frames 1-2 -> no hit; the same overlap in frame 3 -> collision=1.
REQ-039 SHALL cover: in HIT, game_reset coinciding with a tick and overlap -> collision=0, hit_x=hit_y=0, state GRACE/ARMED per macro.
REQ-040 SHALL cover: 1100 overlap pixels in one frame -> overlap_cnt saturates at 1023; hard_reset mid-frame -> all outputs 0 asynchronously, armed=1.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared encodings and widths for the collision detector.
package collision_pkg;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        GRACE = 2'b00,
        ARMED = 2'b01,
        HIT   = 2'b10
    } state_e;
endpackage

// File: rtl/overlap_counter.sv
// Per-frame saturating overlap counter with capture of the frame's first overlap coordinate.
module overlap_counter
    import collision_pkg::*;
(
    input  logic               clk,
    input  logic               hard_reset,
    input  logic               clear_i,
    input  logic               ovl_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [CNT_W-1:0]   cnt_eval_o,
    output logic [COORD_W-1:0] first_x_o,
    output logic [COORD_W-1:0] first_y_o
);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic               first_ovl;

    // A zero count doubles as the "no overlap yet this frame" flag; saturation never returns it to 0.
    assign first_ovl  = ovl_i && (cnt_q == '0);
    assign cnt_eval_o = (ovl_i && (cnt_q != CNT_MAX)) ? cnt_q + 10'd1 : cnt_q;
    assign first_x_o  = first_ovl ? pixel_x_i : fx_q;
    assign first_y_o  = first_ovl ? pixel_y_i : fy_q;
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = clear_i ? '0 : cnt_eval_o;
        fx_d  = first_x_o;
        fy_d  = first_y_o;
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            cnt_q <= '0;
            fx_q  <= '0;
            fy_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            fx_q  <= fx_d;
            fy_q  <= fy_d;
        end
    end
endmodule

// File: rtl/collision_detector.sv
// Player/obstacle collision detector: per-frame overlap count, hit latch and optional
// post-reset grace period enabled by COLLISION_GRACE_EN.
module collision_detector
    import collision_pkg::*;
#(
    parameter int MIN_OVERLAP  = 4,
    parameter int GRACE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               hard_reset,
    input  logic               game_en,
    input  logic               game_reset,
    input  logic               frame_tick,
    input  logic               video_on,
    input  logic               player_on,
    input  logic               obstacle_on,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic               collision,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y,
    output logic               armed
);
    localparam logic [CNT_W-1:0] MIN_LD = CNT_W'(MIN_OVERLAP);

    logic               overlap;
    logic [CNT_W-1:0]   overlap_cnt, cnt_eval;
    logic [COORD_W-1:0] first_x, first_y;
    logic               fire;
    state_e             state_q, state_d;
    logic               col_q, col_d;
    logic [COORD_W-1:0] hx_q, hx_d, hy_q, hy_d;

    assign overlap = video_on & player_on & obstacle_on & game_en;

    overlap_counter u_ovl (
        .clk        (clk),
        .hard_reset (hard_reset),
        .clear_i    (game_reset | frame_tick),
        .ovl_i      (overlap),
        .pixel_x_i  (pixel_x),
        .pixel_y_i  (pixel_y),
        .cnt_o      (overlap_cnt),
        .cnt_eval_o (cnt_eval),
        .first_x_o  (first_x),
        .first_y_o  (first_y)
    );

    assign fire = (state_q == ARMED) && frame_tick && game_en && (cnt_eval >= MIN_LD);

`ifdef COLLISION_GRACE_EN
    localparam logic [7:0] GRACE_LD = 8'(GRACE_FRAMES);
    logic [7:0] grace_q, grace_d;

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) grace_q <= '0;
        else            grace_q <= grace_d;
    end
`else
    logic unused_grace;
    assign unused_grace = ^8'(GRACE_FRAMES);
`endif

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) state_q <= ARMED;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
`ifdef COLLISION_GRACE_EN
        grace_d = grace_q;
`endif
        if (game_reset) begin
`ifdef COLLISION_GRACE_EN
            state_d = GRACE;
            grace_d = GRACE_LD;
`else
            state_d = ARMED;
`endif
        end else begin
            case (state_q)
                GRACE: begin
`ifdef COLLISION_GRACE_EN
                    if (frame_tick && game_en) begin
                        if (grace_q <= 8'd1) begin
                            grace_d = '0;
                            state_d = ARMED;
                        end else begin
                            grace_d = grace_q - 8'd1;
                        end
                    end
`else
                    state_d = ARMED;
`endif
                end
                ARMED:   if (fire) state_d = HIT;
                HIT:     state_d = HIT;
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        col_d = col_q;
        hx_d  = hx_q;
        hy_d  = hy_q;
        if (game_reset) begin
            col_d = 1'b0;
            hx_d  = '0;
            hy_d  = '0;
        end else if (fire) begin
            col_d = 1'b1;
            hx_d  = first_x;
            hy_d  = first_y;
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            col_q <= 1'b0;
            hx_q  <= '0;
            hy_q  <= '0;
        end else begin
            col_q <= col_d;
            hx_q  <= hx_d;
            hy_q  <= hy_d;
        end
    end

    always_comb begin
        armed     = (state_q == ARMED);
        collision = col_q;
        hit_x     = hx_q;
        hit_y     = hy_q;
    end
endmodule

// File: tb/tb_collision_detector.sv
// Directed plus randomized bench for collision_detector against a frame-level reference model.
module tb_collision_detector;
    localparam int MIN_OVL = 4;
    localparam int GRACE   = 2;
`ifdef COLLISION_GRACE_EN
    localparam bit GRACE_ON = 1'b1;
`else
    localparam bit GRACE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       hard_reset, game_en, game_reset, frame_tick;
    logic       video_on, player_on, obstacle_on;
    logic [9:0] pixel_x, pixel_y;
    logic       collision, armed;
    logic [9:0] hit_x, hit_y;

    collision_detector #(.MIN_OVERLAP(MIN_OVL), .GRACE_FRAMES(GRACE)) dut (
        .clk         (clk),
        .hard_reset  (hard_reset),
        .game_en     (game_en),
        .game_reset  (game_reset),
        .frame_tick  (frame_tick),
        .video_on    (video_on),
        .player_on   (player_on),
        .obstacle_on (obstacle_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .collision   (collision),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: 0=grace, 1=armed, 2=hit; m_cnt is the true (unbounded) overlap count.
    int m_st, m_grace, m_cnt, m_fx, m_fy, m_hx, m_hy;
    bit m_col;

    function automatic int sat(input int c);
        return (c > 1023) ? 1023 : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_hard_reset();
        m_st = 1; m_col = 0; m_hx = 0; m_hy = 0; m_cnt = 0; m_grace = 0;
    endtask

    task automatic model_edge(input bit ovl, input int x, input int y, input bit tick,
                              input bit gr, input bit en);
        if (gr) begin
            m_col = 0; m_hx = 0; m_hy = 0; m_cnt = 0; m_grace = GRACE;
            m_st = GRACE_ON ? 0 : 1;
            return;
        end
        if (ovl && en) begin
            if (m_cnt == 0) begin m_fx = x; m_fy = y; end
            m_cnt++;
        end
        if (tick) begin
            if (m_st == 1 && en && sat(m_cnt) >= MIN_OVL) begin
                m_st = 2; m_col = 1; m_hx = m_fx; m_hy = m_fy;
            end else if (m_st == 0 && en) begin
                if (m_grace <= 1) begin m_grace = 0; m_st = 1; end
                else m_grace--;
            end
            m_cnt = 0;
        end
    endtask

    task automatic check_all();
        chk("collision", collision, m_col);
        chk("hit_x", hit_x, m_hx);
        chk("hit_y", hit_y, m_hy);
        chk("armed", armed, (m_st == 1));
        chk("overlap_cnt", dut.overlap_cnt, sat(m_cnt));
    endtask

    task automatic cyc(input bit v, input bit p, input bit o, input int x, input int y,
                       input bit tick, input bit gr, input bit en);
        video_on = v; player_on = p; obstacle_on = o;
        pixel_x = 10'(x); pixel_y = 10'(y);
        frame_tick = tick; game_reset = gr; game_en = en;
        @(posedge clk);
        model_edge(v & p & o, x, y, tick, gr, en);
        #1;
        check_all();
        frame_tick = 1'b0; game_reset = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        cyc(1, 1, 1, x, y, 0, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, i, 0, 0, 0, 1);
    endtask

    task automatic tick(input bit ovl, input int x, input int y);
        cyc(1, ovl, 1, x, y, 1, 0, 1);
    endtask

    task automatic greset();
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    // Called right after a cyc (edge+1): pulses hard_reset entirely between clock edges.
    task automatic hreset_async();
        #2 hard_reset = 1'b1;
        #1;
        model_hard_reset();
        check_all();
        #2 hard_reset = 1'b0;
    endtask

    initial begin
        hard_reset = 1'b1; game_en = 1'b0; game_reset = 1'b0; frame_tick = 1'b0;
        video_on = 1'b0; player_on = 1'b0; obstacle_on = 1'b0;
        pixel_x = '0; pixel_y = '0;
        m_fx = 0; m_fy = 0;
        repeat (2) @(posedge clk);
        #1;
        model_hard_reset();
        check_all();
        chk("rst_armed", armed, 1);
        chk("rst_collision", collision, 0);
        hard_reset = 1'b0;

        // Four overlap pixels from (100,200), then a clean tick.
        pix(100, 200); pix(101, 200); pix(102, 200); pix(103, 200);
        idle(2);
        chk("pre_tick_collision", collision, 0);
        tick(0, 5, 5);
        chk("hit_collision", collision, 1);
        chk("hit_x_100", hit_x, 100);
        chk("hit_y_200", hit_y, 200);
        chk("hit_not_armed", armed, 0);

        // HIT holds through further frames and game_en changes.
        pix(10, 10); pix(11, 10); cyc(1, 1, 1, 12, 10, 1, 0, 0);
        for (int i = 0; i < 6; i++) pix(20 + i, 30);
        tick(1, 40, 40);
        chk("hit_hold_x", hit_x, 100);

        // game_reset coinciding with tick and overlap while in HIT.
        pix(300, 300);
        cyc(1, 1, 1, 301, 302, 1, 1, 1);
        chk("gr_collision", collision, 0);
        chk("gr_hit_x", hit_x, 0);
        chk("gr_hit_y", hit_y, 0);
        chk("gr_armed", armed, GRACE_ON ? 0 : 1);

        // Three overlaps: below threshold.
        hreset_async();
        pix(1, 2); pix(2, 2); pix(3, 2);
        tick(0, 0, 0);
        chk("three_no_hit", collision, 0);
        chk("three_cnt_cleared", dut.overlap_cnt, 0);

        // Three overlaps plus one on the tick cycle.
        pix(50, 60); pix(51, 60); idle(1); pix(52, 60);
        tick(1, 53, 60);
        chk("tick_pix_hit", collision, 1);
        chk("tick_pix_hit_x", hit_x, 50);
        chk("tick_pix_hit_y", hit_y, 60);

        // game_en low: overlaps not counted, tick not evaluated.
        hreset_async();
        for (int i = 0; i < 6; i++) cyc(1, 1, 1, i, 7, 0, 0, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 6; i++) pix(i, 8);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        chk("en_low_no_hit", collision, 0);

`ifdef COLLISION_GRACE_EN
        // Two grace frames swallow heavy overlap; the third frame hits.
        greset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) pix(200 + f, 100 + i);
            tick(0, 0, 0);
            chk("grace_frame_col", collision, (f == 2));
        end
        chk("grace_hit_x", hit_x, 202);
`endif

        // Saturation, then asynchronous reset mid-frame.
        greset();
        for (int i = 0; i < 1100; i++) pix(i % 640, 9);
        chk("sat_cnt", dut.overlap_cnt, 1023);
        hreset_async();
        chk("hrst_collision", collision, 0);
        chk("hrst_cnt", dut.overlap_cnt, 0);
        chk("hrst_armed", armed, 1);
        pix(5, 5); pix(6, 5); pix(7, 5);
        tick(0, 0, 0);
        chk("post_hrst_no_hit", collision, 0);

        // Randomized frames.
        for (int f = 0; f < 80; f++) begin
            int n;
            if (m_col && ($urandom % 2 == 0)) greset();
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++)
                cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
                    $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0,
                    ($urandom % 10) != 0);
            cyc(1, ($urandom % 2) != 0, 1, $urandom_range(0, 1023), $urandom_range(0, 1023),
                1, ($urandom % 15) == 0, ($urandom % 8) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
